nes_pad_responder: RTL and testbench
====================================

NES_PAD_RESPONDER -- requirements
Module: nes_pad_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on nes_latch and nes_clk (minimum 2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, clk cycles without an nes_clk rising edge before an abandoned SHIFT is dropped.
REQ-003 SHALL have port clk, input, 1, system clock; the block uses one clock.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port buttons, input, 8, active-high pressed state: [0]=A [1]=B [2]=Select [3]=Start [4]=Up [5]=Down [6]=Left [7]=Right.
REQ-006 SHALL have port nes_latch, input, 1, host latch pin, asynchronous to clk.
REQ-007 SHALL have port nes_clk, input, 1, host shift-clock pin, asynchronous to clk.
REQ-008 SHALL have port nes_data, output, 1, serial data to host, active-low (0 = pressed), registered.
REQ-009 SHALL have port poll_done, output, 1, one-cycle pulse when the 8th bit has been shifted.
REQ-010 SHALL have port busy, output, 1, high in LOAD or SHIFT.

Function
REQ-011 SHALL pass nes_latch and nes_clk through SYNC_STAGES-flop synchronizers, then one edge-detect register each.
REQ-012 SHALL implement states IDLE, LOAD, SHIFT, DONE.
REQ-013 IDLE: nes_data=1; nes_clk edges ignored; synced latch high -> LOAD.
REQ-014 LOAD: SHALL reload the snapshot from buttons every cycle; nes_data=~buttons[0] (snapshot bit 0); nes_clk edges ignored; synced latch falling edge -> SHIFT, snapshot frozen, bit_idx=0.
REQ-015 SHIFT: on each synced nes_clk rising edge SHALL increment bit_idx (4-bit, 0..8) and drive nes_data=~snapshot[bit_idx]; when bit_idx reaches 8 -> DONE, nes_data=1, poll_done=1 for one cycle.
REQ-016 DONE: nes_data=1; further nes_clk edges leave nes_data at 1; synced latch high -> LOAD.
REQ-017 Latch rising edge in any state, including mid-SHIFT, SHALL win over a simultaneous nes_clk edge and go to LOAD.
REQ-018 SHIFT SHALL use a 12-bit idle counter cleared on every nes_clk rising edge; reaching TIMEOUT_CYCLES-1 -> IDLE, nes_data=1, no poll_done.
REQ-019 Latency from a pin edge first sampled at a clk edge to the nes_data change SHALL be exactly SYNC_STAGES+2 clk cycles (sync, edge detect, output register).
REQ-020 busy SHALL be combinational from state; poll_done and nes_data SHALL be registered.
REQ-021 Changes on buttons during SHIFT or DONE SHALL NOT affect the bits shifted out.

Reset
REQ-022 On rst_n low SHALL force state=IDLE, nes_data=1, poll_done=0, busy=0, snapshot=0, bit_idx=0, idle counter=0, and all synchronizer/edge flops to 0, asynchronously.
REQ-023 Reset released mid-transfer SHALL resume in IDLE; a latch already held high SHALL produce no rising edge until it is low for at least one synced sample.

Structure
REQ-024 State encoding, button bit-index constants (BTN_A..BTN_RIGHT) and the NES_BITS=8 constant SHALL be in the shared package nes_pkg, which the future NES receiver also uses.
REQ-025 SHALL instantiate sub-module nes_pin_sync (SYNC_STAGES flops plus rise/fall detect) once per host pin.

Verification
REQ-026 buttons=8'b0000_0101, latch pulse then 8 nes_clk pulses -> nes_data sequence 0,1,0,1,1,1,1,1, then 1; poll_done pulses once.
REQ-027 buttons changed from 8'hFF to 8'h00 after latch falls -> all 8 bits read 0 (snapshot 8'hFF).
REQ-028 latch re-asserted after 3 clocks of a transfer with buttons=8'h80 -> back in LOAD, nes_data=1 (A not pressed), next full read ends with 0 on bit 7.
REQ-029 Latch fall then no nes_clk for 4096 cycles -> state IDLE, nes_data=1, poll_done never asserted.
REQ-030 rst_n pulsed low mid-SHIFT at bit 4 -> nes_data=1 and busy=0 immediately, without a clk edge.
REQ-031 Latch rising and clock rising in the same synced cycle during SHIFT -> LOAD taken, bit_idx not incremented, nes_data=~buttons[0] after SYNC_STAGES+2 cycles.

Source files
------------

// File: rtl/nes_pkg.sv
// nes_pkg: shared NES controller constants and state encoding for responder and receiver
package nes_pkg;
  localparam int NES_BITS = 8;
  localparam int BTN_A = 0;
  localparam int BTN_B = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START = 3;
  localparam int BTN_UP = 4;
  localparam int BTN_DOWN = 5;
  localparam int BTN_LEFT = 6;
  localparam int BTN_RIGHT = 7;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} nes_state_e;
endpackage

// File: rtl/nes_pin_sync.sv
// nes_pin_sync: multi-flop synchronizer for an async host pin with registered rise/fall pulses
module nes_pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync, vld;
  logic level, armed;
  // armed only after a genuine low sample, so a pin held high across reset never looks like a rise
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= '0;
      vld <= '0;
      level <= 1'b0;
      armed <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], pin};
      vld <= {vld[STAGES-2:0], 1'b1};
      level <= sync[STAGES-1];
      armed <= armed | (vld[STAGES-1] & ~sync[STAGES-1]);
      rise <= armed & sync[STAGES-1] & ~level;
      fall <= level & ~sync[STAGES-1];
    end
endmodule

// File: rtl/nes_pad_responder.sv
// nes_pad_responder: emulates an NES controller shift register answering host latch/clock
module nes_pad_responder import nes_pkg::*; #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] buttons,
  input  logic       nes_latch,
  input  logic       nes_clk,
  output logic       nes_data,
  output logic       poll_done,
  output logic       busy
);
  nes_state_e state, state_n;
  logic [7:0] snap, snap_n;
  logic [3:0] bit_idx, bit_idx_n;
  logic [11:0] idle_cnt, idle_cnt_n;
  logic data_n, done_n;
  logic latch_rise, latch_fall, clk_rise, clk_fall_unused;
  nes_pin_sync #(.STAGES(SYNC_STAGES)) u_latch_sync (
    .clk(clk), .rst_n(rst_n), .pin(nes_latch), .rise(latch_rise), .fall(latch_fall)
  );
  nes_pin_sync #(.STAGES(SYNC_STAGES)) u_clk_sync (
    .clk(clk), .rst_n(rst_n), .pin(nes_clk), .rise(clk_rise), .fall(clk_fall_unused)
  );
  assign busy = (state == LOAD) || (state == SHIFT);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      snap <= '0;
      bit_idx <= '0;
      idle_cnt <= '0;
      nes_data <= 1'b1;
      poll_done <= 1'b0;
    end else begin
      state <= state_n;
      snap <= snap_n;
      bit_idx <= bit_idx_n;
      idle_cnt <= idle_cnt_n;
      nes_data <= data_n;
      poll_done <= done_n;
    end
  always_comb begin
    state_n = state;
    snap_n = snap;
    bit_idx_n = bit_idx;
    idle_cnt_n = idle_cnt;
    data_n = 1'b1;
    done_n = 1'b0;
    if (latch_rise) begin
      state_n = LOAD;
      snap_n = buttons;
      bit_idx_n = '0;
      idle_cnt_n = '0;
      data_n = ~buttons[BTN_A];
    end else begin
      case (state)
        LOAD: begin
          bit_idx_n = '0;
          idle_cnt_n = '0;
          state_n = latch_fall ? SHIFT : LOAD;
          snap_n = latch_fall ? snap : buttons;
          data_n = latch_fall ? ~snap[BTN_A] : ~buttons[BTN_A];
        end
        SHIFT: begin
          data_n = ~snap[bit_idx[2:0]];
          if (clk_rise) begin
            bit_idx_n = bit_idx + 4'd1;
            idle_cnt_n = '0;
            done_n = (bit_idx_n == 4'(NES_BITS));
            state_n = done_n ? DONE : SHIFT;
            data_n = done_n ? 1'b1 : ~snap[bit_idx_n[2:0]];
          end else if (idle_cnt == 12'(TIMEOUT_CYCLES - 1)) begin
            state_n = IDLE;
            bit_idx_n = '0;
            idle_cnt_n = '0;
            data_n = 1'b1;
          end else begin
            idle_cnt_n = idle_cnt + 12'd1;
          end
        end
        default: data_n = 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_nes_pad_responder.sv
// tb_nes_pad_responder: table-driven reads plus directed corner sequences for the NES responder
module tb_nes_pad_responder;
  logic clk = 1'b0;
  logic rst_n, nes_latch, nes_clk;
  logic [7:0] buttons;
  logic nes_data, poll_done, busy;
  int checks = 0;
  int passed = 0;
  int pd_cnt = 0;
  typedef struct {
    logic [7:0] btn;
    logic [7:0] after;
    logic [8:0] exp;
  } vec_t;
  vec_t vt[6];
  nes_pad_responder dut (
    .clk(clk), .rst_n(rst_n), .buttons(buttons), .nes_latch(nes_latch),
    .nes_clk(nes_clk), .nes_data(nes_data), .poll_done(poll_done), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (poll_done === 1'b1) pd_cnt++;
  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_clk(input int n);
    for (int i = 0; i < n; i++) begin
      nes_clk = 1'b1;
      cyc(6);
      nes_clk = 1'b0;
      cyc(6);
    end
  endtask
  task automatic read_pad(input string nm, input logic [7:0] btn, input logic [7:0] after,
                          input logic [8:0] exp);
    logic [8:0] got;
    int pd0;
    buttons = btn;
    nes_latch = 1'b1;
    cyc(6);
    chk({nm, "_load_busy"}, {15'b0, busy}, 16'd1);
    chk({nm, "_load_data"}, {15'b0, nes_data}, {15'b0, !btn[0]});
    nes_latch = 1'b0;
    pd0 = pd_cnt;
    cyc(6);
    got[0] = nes_data;
    buttons = after;
    for (int i = 1; i <= 8; i++) begin
      nes_clk = 1'b1;
      cyc(6);
      got[i] = nes_data;
      nes_clk = 1'b0;
      cyc(6);
    end
    chk({nm, "_seq"}, {7'b0, got}, {7'b0, exp});
    chk({nm, "_poll_done"}, 16'(pd_cnt - pd0), 16'd1);
    chk({nm, "_done_busy"}, {15'b0, busy}, 16'd0);
  endtask
  initial begin
    int pd0;
    vt[0] = '{8'h05, 8'h05, 9'h1FA};
    vt[1] = '{8'hFF, 8'h00, 9'h100};
    vt[2] = '{8'h00, 8'hFF, 9'h1FF};
    vt[3] = '{8'hA5, 8'hA5, 9'h15A};
    vt[4] = '{8'h3C, 8'hC3, 9'h1C3};
    vt[5] = '{8'h80, 8'h80, 9'h17F};
    rst_n = 1'b0;
    nes_latch = 1'b0;
    nes_clk = 1'b0;
    buttons = 8'h00;
    cyc(3);
    chk("rst_data", {15'b0, nes_data}, 16'd1);
    chk("rst_busy", {15'b0, busy}, 16'd0);
    chk("rst_poll", {15'b0, poll_done}, 16'd0);
    nes_latch = 1'b1;
    cyc(1);
    rst_n = 1'b1;
    cyc(20);
    chk("held_latch_no_load", {15'b0, busy}, 16'd0);
    nes_latch = 1'b0;
    cyc(6);
    nes_latch = 1'b1;
    cyc(6);
    chk("relatch_load", {15'b0, busy}, 16'd1);
    for (int i = 0; i < 6; i++) read_pad($sformatf("vec%0d", i), vt[i].btn, vt[i].after, vt[i].exp);
    buttons = 8'h80;
    nes_latch = 1'b1;
    cyc(6);
    nes_latch = 1'b0;
    cyc(6);
    pulse_clk(3);
    nes_latch = 1'b1;
    cyc(6);
    chk("abort_busy", {15'b0, busy}, 16'd1);
    chk("abort_data", {15'b0, nes_data}, 16'd1);
    read_pad("abort_reread", 8'h80, 8'h80, 9'h17F);
    buttons = 8'h00;
    nes_latch = 1'b1;
    cyc(6);
    nes_latch = 1'b0;
    cyc(6);
    pulse_clk(2);
    buttons = 8'h01;
    nes_latch = 1'b1;
    nes_clk = 1'b1;
    cyc(3);
    chk("race_before_latency", {15'b0, nes_data}, 16'd1);
    cyc(1);
    chk("race_at_latency", {15'b0, nes_data}, 16'd0);
    chk("race_busy", {15'b0, busy}, 16'd1);
    nes_latch = 1'b0;
    nes_clk = 1'b0;
    cyc(6);
    chk("race_bit0", {15'b0, nes_data}, 16'd0);
    pulse_clk(1);
    chk("race_bit1", {15'b0, nes_data}, 16'd1);
    buttons = 8'hFF;
    nes_latch = 1'b1;
    cyc(6);
    nes_latch = 1'b0;
    cyc(6);
    pulse_clk(4);
    chk("mid_shift_data", {15'b0, nes_data}, 16'd0);
    chk("mid_shift_busy", {15'b0, busy}, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_data", {15'b0, nes_data}, 16'd1);
    chk("async_rst_busy", {15'b0, busy}, 16'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(6);
    buttons = 8'h01;
    nes_latch = 1'b1;
    cyc(6);
    nes_latch = 1'b0;
    pd0 = pd_cnt;
    cyc(4000);
    chk("timeout_pre_busy", {15'b0, busy}, 16'd1);
    chk("timeout_pre_data", {15'b0, nes_data}, 16'd0);
    cyc(110);
    chk("timeout_busy", {15'b0, busy}, 16'd0);
    chk("timeout_data", {15'b0, nes_data}, 16'd1);
    chk("timeout_no_poll", 16'(pd_cnt - pd0), 16'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
